// File: rtl/wb_rxfifo_pkg.sv
// rtl/wb_rxfifo_pkg.sv - shared widths and depth helpers for the receive FIFO
package wb_rxfifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WB_W   = 32;

  // One slot stays free, so a 2^aw buffer holds 2^aw - 1 bytes.
  function automatic int unsigned fifo_capacity(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  function automatic int unsigned fifo_half(input int unsigned aw);
    return 32'd1 << (aw - 32'd1);
  endfunction

endpackage

// File: rtl/wb_rxfifo_sync_fifo.sv
// rtl/wb_rxfifo_sync_fifo.sv - byte circular buffer with pointers, count and level flags
module wb_rxfifo_sync_fifo
  import wb_rxfifo_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic [AW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              half_full
);

  localparam logic [AW-1:0] CAPACITY = AW'(fifo_capacity(AW));
  localparam logic [AW-1:0] HALF     = AW'(fifo_half(AW));
  localparam logic [AW-1:0] ONE      = AW'(1);

  logic [BYTE_W-1:0] mem [2**AW];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_en;
  logic              pop_en;

  // Gating uses registered flags only, so a pop never frees room for a same-cycle push.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign empty     = (count == '0);
  assign full      = (count == CAPACITY);
  assign half_full = (count >= HALF);
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_rxfifo.sv
// rtl/wb_rxfifo.sv - 8-bit stream receive FIFO exposed as a read-only pipelined WB slave
module wb_rxfifo
  import wb_rxfifo_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  output logic                       o_wb_stall,
  output logic                       o_wb_ack,
  input  logic                       i_wb_we,
  output logic [WB_W-1:0]            o_wb_data,
  input  logic                       i_rx_valid,
  output logic                       o_rx_ready,
  input  logic [BYTE_W-1:0]          i_rx_data,
  output logic [FIFO_ADDR_WIDTH-1:0] o_fifo_count,
  output logic                       o_fifo_empty,
  output logic                       o_fifo_full,
  output logic                       o_fifo_half_full,
  output logic                       o_fifo_overflow,
  output logic                       o_fifo_underflow
);

  logic              wb_req;
  logic              rd_req;
  logic [BYTE_W-1:0] pop_data;

  assign wb_req     = i_wb_cyc && i_wb_stb;
  assign rd_req     = wb_req && !i_wb_we;
  assign o_wb_stall = 1'b0;
  assign o_rx_ready = !o_fifo_full;

  wb_rxfifo_sync_fifo #(
    .AW (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (i_rx_valid),
    .push_data (i_rx_data),
    .pop       (rd_req),
    .pop_data  (pop_data),
    .count     (o_fifo_count),
    .empty     (o_fifo_empty),
    .full      (o_fifo_full),
    .half_full (o_fifo_half_full)
  );

  // Writes and empty reads still ack, returning zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack         <= 1'b0;
      o_wb_data        <= '0;
      o_fifo_overflow  <= 1'b0;
      o_fifo_underflow <= 1'b0;
    end else begin
      o_wb_ack         <= wb_req;
      o_wb_data        <= (rd_req && !o_fifo_empty) ? {{(WB_W-BYTE_W){1'b0}}, pop_data} : '0;
      o_fifo_overflow  <= i_rx_valid && o_fifo_full;
      o_fifo_underflow <= rd_req && o_fifo_empty;
    end
  end

endmodule

// File: tb/tb_wb_rxfifo.sv
// tb/tb_wb_rxfifo.sv - table-driven directed bench for wb_rxfifo with AW=3
module tb_wb_rxfifo;

  localparam int unsigned AW = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_wb_cyc = 1'b0;
  logic          i_wb_stb = 1'b0;
  logic          o_wb_stall;
  logic          o_wb_ack;
  logic          i_wb_we = 1'b0;
  logic [31:0]   o_wb_data;
  logic          i_rx_valid = 1'b0;
  logic          o_rx_ready;
  logic [7:0]    i_rx_data = 8'h00;
  logic [AW-1:0] o_fifo_count;
  logic          o_fifo_empty;
  logic          o_fifo_full;
  logic          o_fifo_half_full;
  logic          o_fifo_overflow;
  logic          o_fifo_underflow;

  int checks = 0;
  int passed = 0;

  wb_rxfifo #(.FIFO_ADDR_WIDTH(AW)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_wb_cyc         (i_wb_cyc),
    .i_wb_stb         (i_wb_stb),
    .o_wb_stall       (o_wb_stall),
    .o_wb_ack         (o_wb_ack),
    .i_wb_we          (i_wb_we),
    .o_wb_data        (o_wb_data),
    .i_rx_valid       (i_rx_valid),
    .o_rx_ready       (o_rx_ready),
    .i_rx_data        (i_rx_data),
    .o_fifo_count     (o_fifo_count),
    .o_fifo_empty     (o_fifo_empty),
    .o_fifo_full      (o_fifo_full),
    .o_fifo_half_full (o_fifo_half_full),
    .o_fifo_overflow  (o_fifo_overflow),
    .o_fifo_underflow (o_fifo_underflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        valid;
    logic [7:0]  rxd;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  cnt;
    logic        ack;
    logic [31:0] dat;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic valid, input logic [7:0] rxd, input logic cyc,
                              input logic stb, input logic we, input logic [2:0] cnt,
                              input logic ack, input logic [31:0] dat, input logic ovf,
                              input logic unf);
    vec_t v;
    v.valid = valid; v.rxd = rxd; v.cyc = cyc; v.stb = stb; v.we = we;
    v.cnt = cnt; v.ack = ack; v.dat = dat; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic step(input logic valid, input logic [7:0] rxd, input logic cyc,
                      input logic stb, input logic we);
    i_rx_valid = valid;
    i_rx_data  = rxd;
    i_wb_cyc   = cyc;
    i_wb_stb   = stb;
    i_wb_we    = we;
    @(posedge i_clk);
    #1;
  endtask

  // Flags come from the spec formulas for AW=3: capacity 7, half at 4.
  task automatic chk(input string name, input logic [2:0] cnt, input logic ack,
                     input logic [31:0] dat, input logic ovf, input logic unf);
    logic [43:0] got;
    logic [43:0] exp;
    logic e, f, h;
    e = (cnt == 3'd0);
    f = (cnt == 3'd7);
    h = (cnt >= 3'd4);
    got = {o_fifo_count, o_fifo_empty, o_fifo_full, o_fifo_half_full, o_rx_ready,
           o_wb_ack, o_wb_data, o_fifo_overflow, o_fifo_underflow, o_wb_stall};
    exp = {cnt, e, f, h, !f, ack, dat, ovf, unf, 1'b0};
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got cnt=%0d emp=%b full=%b half=%b rdy=%b ack=%b data=%h ovf=%b unf=%b stall=%b, expected cnt=%0d emp=%b full=%b half=%b rdy=%b ack=%b data=%h ovf=%b unf=%b stall=0",
               name, o_fifo_count, o_fifo_empty, o_fifo_full, o_fifo_half_full, o_rx_ready,
               o_wb_ack, o_wb_data, o_fifo_overflow, o_fifo_underflow, o_wb_stall,
               cnt, e, f, h, !f, ack, dat, ovf, unf);
    end
  endtask

  initial begin
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(1, 8'(k-1), 0, 0, 0, 3'(k), 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h07, 0, 0, 0, 3'd7, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h07, 0, 0, 0, 3'd7, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 3'd7, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 3'd7, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 8'h00, 1, 1, 0, (i < 7) ? 3'(6-i) : 3'd0, 1,
                        (i < 7) ? 32'(i) : 32'd0, 0, (i >= 7)));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h10, 0, 0, 0, 3'd1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 3'd2, 0, 0, 0, 0));
    for (int j = 0; j < 5; j++)
      vecs.push_back(mk(1, 8'(8'h12 + j), 1, 1, 0, 3'd2, 1, 32'(8'h10 + j), 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 3'd1, 1, 32'h15, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 3'd0, 1, 32'h16, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 1, 1, 0, 3'd1, 1, 32'h0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 3'd1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 3'd0, 1, 32'hAA, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 3'd0, 0, 32'h0, 0, 0));

    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_held", 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("reset_released", 0, 0, 0, 0, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].valid, vecs[n].rxd, vecs[n].cyc, vecs[n].stb, vecs[n].we);
      chk($sformatf("vec%0d", n), vecs[n].cnt, vecs[n].ack, vecs[n].dat, vecs[n].ovf, vecs[n].unf);
    end

    // Full with a same-cycle pop: the offered byte must be refused.
    for (int k = 0; k < 7; k++) step(1, 8'(8'h30 + k), 0, 0, 0);
    chk("filled", 7, 0, 0, 0, 0);
    step(1, 8'h99, 1, 1, 0);
    chk("full_pop", 6, 1, 32'h30, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("full_pop_after", 6, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 8'h00, 1, 1, 0);
    chk("drain_last", 0, 1, 32'h36, 0, 0);

    // Asynchronous reset in the middle of a transfer.
    for (int k = 0; k < 5; k++) step(1, 8'(8'h20 + k), 0, 0, 0);
    step(1, 8'h25, 1, 1, 0);
    chk("pre_reset", 5, 1, 32'h20, 0, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_rxfifo.md
Name: wb_rxfifo

Overview:
Receive FIFO bridging an 8-bit ready/valid input stream to a 32-bit pipelined Wishbone slave (read-only data port). Each accepted WB read pops one byte, returned zero-extended. FIFO status (count, empty/full/half-full, overflow/underflow pulses) is exported for interrupt or status logic. Sits between a receive datapath (e.g. a UART or ADC sampler) and the WB interconnect.

Parameters:
FIFO_ADDR_WIDTH, 8, log2 of storage depth; usable capacity = 2^FIFO_ADDR_WIDTH - 1 entries (one slot is kept free).

Ports:
i_clk  in  1  system clock, all logic rising-edge.
i_rst_n  in  1  asynchronous active-low reset.
i_wb_cyc  in  1  WB cycle.
i_wb_stb  in  1  WB strobe.
o_wb_stall  out  1  WB stall; constant 0.
o_wb_ack  out  1  WB acknowledge.
i_wb_we  in  1  WB write enable.
o_wb_data  out  32  WB read data.
i_rx_valid  in  1  stream data valid.
o_rx_ready  out  1  stream ready = !o_fifo_full.
i_rx_data  in  8  stream data byte.
o_fifo_count  out  FIFO_ADDR_WIDTH  current entry count.
o_fifo_empty  out  1  count == 0.
o_fifo_full  out  1  count == 2^FIFO_ADDR_WIDTH-1.
o_fifo_half_full  out  1  count >= 2^(FIFO_ADDR_WIDTH-1).
o_fifo_overflow  out  1  one-cycle pulse, see below.
o_fifo_underflow  out  1  one-cycle pulse, see below.

Behaviour:
- Reset (async assert, sync release in the system): wr/rd pointers and count = 0, o_wb_ack=0, o_wb_data=0, overflow=underflow=0. Hence empty=1, full=0, half_full=0, rx_ready=1.
- Storage: circular buffer of 2^AW bytes, wr/rd pointers AW bits, wrap modulo 2^AW naturally; count register AW bits.
- Push: i_rx_valid && o_rx_ready at edge N -> byte written at wr_ptr, wr_ptr++. Count/flags reflect it from cycle N+1.
- WB request accepted = i_wb_cyc && i_wb_stb (stall is always 0; one request per cycle allowed).
- Read request (we=0): if not empty, pop byte at rd_ptr, rd_ptr++; o_wb_data <= {24'h0, byte}. If empty, no pop, o_wb_data <= 0, o_fifo_underflow pulses next cycle.
- Write request (we=1): no FIFO effect, o_wb_data <= 0, acknowledged normally.
- o_wb_ack registered: 1 exactly one cycle after each accepted request; 0 whenever i_wb_cyc is low in the request cycle. If cyc drops while ack pending, ack still issues once (master ignores it).
- Simultaneous push and pop (non-empty): both occur, count unchanged. Push with pop on empty FIFO: pop is an underflow (no bypass), push stored, count=1.
- Full: rx_ready=0, no write. o_fifo_overflow pulses (registered, next cycle) for every cycle i_rx_valid=1 while full. A pop in the same cycle as full does not enable the push that cycle (ready is from registered state).
- Flags are combinational from registered count, glitch-free at edges.

Decomposition:
No shared package needed; AW derived constants (CAPACITY, HALF) as localparams. Natural single sub-module: sync_fifo (storage, pointers, count, flags) with wb_rxfifo adding the WB slave and pulse logic.

Test Plan:
- Reset with AW=3: count=0, empty=1, full=0, half_full=0, rx_ready=1, ack=0.
- Stream 0x00,0x01,... with valid held: after 4 pushes half_full=1; after 7 pushes full=1, rx_ready=0, count=7; overflow pulses every following cycle valid stays 1.
- WB write (cyc=1, stb=1, we=1) for one cycle: ack exactly one cycle later, data 0, count unchanged.
- Stop stream, 10 single WB reads: returns 0x00000000..0x00000006, count decrements to 0, empty=1. Last 3 reads ack with data 0 and each raises underflow one cycle.
- Continuous stream plus back-to-back reads with FIFO non-empty: count stable, data increments by 1 per read, no overflow/underflow.
- Assert i_rst_n=0 mid-stream with count=5: all outputs immediately return to reset values without waiting for a clock.
